// File: rtl/catraca_gate_ctrl.sv
// Station gate controller: round-robin shares one fare validator among turnstile lanes,
// pulses coin/reject per lane and tracks station occupancy against a capacity limit.
module catraca_gate_ctrl #(
    parameter int unsigned N_LANES     = 4,
    parameter int unsigned CAP_W       = 8,
    parameter int unsigned CAPACITY    = 200,
    parameter int unsigned VAL_TIMEOUT = 16,
    localparam int unsigned LW         = $clog2(N_LANES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LANES-1:0] req_i,
    input  logic [N_LANES-1:0] unlocked_i,
    input  logic [N_LANES-1:0] passed_i,
    input  logic               exit_i,
    output logic [N_LANES-1:0] coin_o,
    output logic [N_LANES-1:0] reject_o,
    output logic               val_req_o,
    output logic [LW-1:0]      val_lane_o,
    input  logic               val_ack_i,
    input  logic               val_ok_i,
    output logic [CAP_W-1:0]   occupancy_o,
    output logic               full_o,
    output logic               busy_o
);

    localparam int unsigned TW = $clog2(VAL_TIMEOUT + 1);
    localparam int unsigned OW = CAP_W + 2;
    localparam logic [OW-1:0] OCC_MAX = {2'b00, {CAP_W{1'b1}}};

    typedef enum logic [1:0] {StIdle, StValidate, StGrant, StReject} state_e;

    state_e             state_q, state_d;
    logic [LW-1:0]      lane_q, lane_d;
    logic [LW-1:0]      rr_q, rr_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CAP_W-1:0]   occ_q, occ_d;

    logic [N_LANES-1:0]   eligible;
    logic [2*N_LANES-1:0] elig_dbl;
    logic [N_LANES-1:0]   elig_rot;
    logic                 pick_valid;
    logic [LW-1:0]        pick_lane;
    logic [LW-1:0]        lane_next;
    logic [N_LANES-1:0]   lane_oh;
    logic [OW-1:0]        occ_sum;

    function automatic logic [OW-1:0] popcnt(input logic [N_LANES-1:0] v);
        logic [OW-1:0] c;
        c = '0;
        for (int i = 0; i < N_LANES; i++) begin
            c = c + {{(OW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Rotate eligibility so bit 0 is the rr pointer; lowest set bit is the winner.
    assign eligible = req_i & ~unlocked_i;
    assign elig_dbl = {eligible, eligible};
    assign elig_rot = elig_dbl[rr_q +: N_LANES];

    always_comb begin
        pick_valid = |elig_rot;
        pick_lane  = '0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                pick_lane = LW'((32'(rr_q) + 32'(k)) % N_LANES);
            end
        end
    end

    assign lane_next = (lane_q == LW'(N_LANES - 1)) ? '0 : lane_q + 1'b1;

    assign full_o = ({2'b00, occ_q} + popcnt(unlocked_i)) >= OW'(CAPACITY);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        rr_d    = rr_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (pick_valid && !full_o) begin
                    lane_d  = pick_lane;
                    state_d = StValidate;
                end
            end
            StValidate: begin
                timer_d = timer_q + 1'b1;
                // An ack in the final timer cycle still takes priority over the timeout.
                if (val_ack_i) begin
                    state_d = val_ok_i ? StGrant : StReject;
                end else if (timer_q == TW'(VAL_TIMEOUT - 1)) begin
                    state_d = StReject;
                end
            end
            StGrant, StReject: begin
                rr_d    = lane_next;
                timer_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        occ_sum = {2'b00, occ_q} + popcnt(passed_i);
        if (exit_i && occ_sum != '0) begin
            occ_sum = occ_sum - 1'b1;
        end
        occ_d = (occ_sum > OCC_MAX) ? {CAP_W{1'b1}} : occ_sum[CAP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lane_q  <= '0;
            rr_q    <= '0;
            timer_q <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            rr_q    <= rr_d;
            timer_q <= timer_d;
            occ_q   <= occ_d;
        end
    end

    always_comb begin
        lane_oh         = '0;
        lane_oh[lane_q] = 1'b1;
    end

    assign coin_o      = (state_q == StGrant) ? lane_oh : '0;
    assign reject_o    = (state_q == StReject) ? lane_oh : '0;
    assign val_req_o   = (state_q == StValidate);
    assign val_lane_o  = lane_q;
    assign occupancy_o = occ_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_catraca_gate_ctrl.sv
// Bench for catraca_gate_ctrl: drives lanes and a validator model; expected coin/reject
// pulses go through a queue that a negedge monitor pops and compares.
module tb_catraca_gate_ctrl;

    localparam int N  = 4;
    localparam int VT = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_i, unlocked_i, passed_i;
    logic         exit_i;
    logic [N-1:0] coin_o, reject_o;
    logic         val_req_o;
    logic [1:0]   val_lane_o;
    logic         val_ack_i, val_ok_i;
    logic [7:0]   occupancy_o;
    logic         full_o, busy_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*N-1:0] exp_q[$];  // {reject, coin}

    always #5 clk = ~clk;

    catraca_gate_ctrl #(
        .N_LANES    (N),
        .CAP_W      (8),
        .CAPACITY   (3),
        .VAL_TIMEOUT(VT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .unlocked_i (unlocked_i),
        .passed_i   (passed_i),
        .exit_i     (exit_i),
        .coin_o     (coin_o),
        .reject_o   (reject_o),
        .val_req_o  (val_req_o),
        .val_lane_o (val_lane_o),
        .val_ack_i  (val_ack_i),
        .val_ok_i   (val_ok_i),
        .occupancy_o(occupancy_o),
        .full_o     (full_o),
        .busy_o     (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int lane);
        return N'(1 << lane);
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (coin_o != '0 || reject_o != '0)) begin
            if (exp_q.size() == 0) check("sb_unexpected", {reject_o, coin_o}, 0);
            else check("sb_order", {reject_o, coin_o}, exp_q.pop_front());
        end
    end

    task automatic wait_val_req(input int lane);
        int i = 0;
        @(negedge clk);
        while (!val_req_o && i < 40) begin
            @(negedge clk);
            i++;
        end
        check("val_req_seen", val_req_o, 1);
        check("val_lane", val_lane_o, lane);
    endtask

    task automatic txn(input int lane, input int dly, input bit ok, input bit drop);
        wait_val_req(lane);
        repeat (dly) @(negedge clk);
        val_ack_i = 1'b1;
        val_ok_i  = ok;
        if (drop) req_i = '0;
        if (ok) exp_q.push_back({{N{1'b0}}, oh(lane)});
        else exp_q.push_back({oh(lane), {N{1'b0}}});
        @(negedge clk);
        val_ack_i = 1'b0;
        val_ok_i  = 1'b0;
        if (ok) check("coin_latency", coin_o, oh(lane));
        else check("reject_latency", reject_o, oh(lane));
        @(negedge clk);
        check("idle_after", busy_o, 0);
    endtask

    task automatic txn_timeout(input int lane);
        int cnt = 1;
        wait_val_req(lane);
        exp_q.push_back({oh(lane), {N{1'b0}}});
        req_i = '0;
        @(negedge clk);
        while (val_req_o && cnt < 60) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_cycles", cnt, VT);
        check("timeout_reject", reject_o, oh(lane));
        @(negedge clk);
        check("idle_after_timeout", busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        rst_n = 1'b0; req_i = '0; unlocked_i = '0; passed_i = '0; exit_i = 1'b0;
        val_ack_i = 1'b0; val_ok_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_occ", occupancy_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_val_req", val_req_o, 0);
        check("rst_val_lane", val_lane_o, 0);
        check("rst_coin", coin_o, 0);
        rst_n = 1'b1;

        // Single grant on lane 0, then a passenger enters
        req_i = 4'b0001;
        txn(0, 3, 1'b1, 1'b1);
        passed_i = 4'b0001;
        @(negedge clk);
        passed_i = '0;
        check("occ_after_pass", occupancy_o, 1);

        // Reset in the middle of a validation
        req_i = 4'b0100;
        wait_val_req(2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_val_req", val_req_o, 0);
        check("midrst_coin", coin_o, 0);
        check("midrst_occ", occupancy_o, 0);
        check("midrst_busy", busy_o, 0);
        req_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy_o, 0);

        // Round-robin with all lanes requesting
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) txn(i % 4, i % 3, 1'b1, i == 4);

        // Refusal, timeout with request dropped, and ack on the final timer cycle
        req_i = 4'b0100;
        txn(2, 2, 1'b0, 1'b1);
        req_i = 4'b0100;
        txn_timeout(2);
        req_i = 4'b1000;
        txn(3, VT - 1, 1'b1, 1'b1);

        // Capacity: 2 inside + 1 unlocked reaches CAPACITY=3
        passed_i = 4'b0011;
        @(negedge clk);
        passed_i = '0;
        check("occ_two", occupancy_o, 2);
        unlocked_i = 4'b0001;
        req_i = 4'b0010;
        @(negedge clk);
        check("full_set", full_o, 1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | int'(val_req_o);
        end
        check("full_no_val_req", seen, 0);
        exit_i = 1'b1;
        @(negedge clk);
        exit_i = 1'b0;
        check("occ_after_exit", occupancy_o, 1);
        check("full_clear", full_o, 0);
        txn(1, 1, 1'b1, 1'b1);
        unlocked_i = '0;

        // Occupancy boundaries
        exit_i = 1'b1;
        @(negedge clk);
        check("occ_to_zero", occupancy_o, 0);
        @(negedge clk);
        exit_i = 1'b0;
        check("occ_floor", occupancy_o, 0);
        passed_i = 4'b0011;
        exit_i = 1'b1;
        @(negedge clk);
        passed_i = '0;
        exit_i = 1'b0;
        check("occ_pass_exit", occupancy_o, 1);

        // Unlocked lane 2 is skipped even though the pointer sits on it
        unlocked_i = 4'b0100;
        req_i = 4'b0101;
        txn(0, 0, 1'b1, 1'b1);
        unlocked_i = '0;

        // Upper clamp
        passed_i = 4'b1111;
        repeat (70) @(negedge clk);
        passed_i = '0;
        check("occ_clamp_top", occupancy_o, 255);
        check("full_at_top", full_o, 1);

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
